// File: rtl/uart_pkg.sv
// Definitions shared by the host-link UART transmitter and receiver:
// state encoding, default bit timing and parity-mode constants.
package uart_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Total bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tim.sv
// Bit-period down-counter: reloads on load or terminal count, counts while
// enabled, and flags tc on the last cycle of each bit period.
module uart_baud_tim #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int                CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load || tc) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready transfer and sends it
// as start bit, LSB-first data, optional parity and stop bit(s) on utx.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = PAR_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 utx,
  output logic                 busy
);

  localparam int               BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_INV   = 1'(PARITY_ODD);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 utx_q, utx_d;
  logic                 xfer;
  logic                 tc;

  // Handshake outputs come from the state register only, never from valid.
  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign utx   = utx_q;
  assign xfer  = valid && ready;

  uart_baud_tim #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tim (
    .clk  (clk),
    .rst_n(rst_n),
    .load (xfer),
    .en   (busy),
    .tc   (tc)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case below leaves one unassigned and infers a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;

    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d  = START;
          shreg_d  = data;
          parity_d = (^data) ^ PAR_INV;
        end
      end
      START: begin
        if (tc) begin
          state_d   = DATA;
          bit_cnt_d = BIT_LAST;
        end
      end
      DATA: begin
        if (tc) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == '0) begin
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
            stop_cnt_d = STOP_LAST;
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tc) begin
          state_d    = STOP;
          stop_cnt_d = STOP_LAST;
        end
      end
      STOP: begin
        if (tc) begin
          if (stop_cnt_q == 1'b0) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is decoded from the next state so utx is a clean flop
  // output that changes on the same edge as the state.
  always_comb begin
    utx_d = 1'b1;
    case (state_d)
      START:   utx_d = 1'b0;
      DATA:    utx_d = shreg_d[0];
      PARITY:  utx_d = parity_d;
      default: utx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      utx_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      utx_q      <= utx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameter variants share one clock; a
// line monitor per instance decodes frames and compares them to queued ones.
module tb_uart_tx;

  localparam int CPB    = 4;
  localparam int BUDGET = 2000;

  typedef struct {
    int         idx;
    logic [11:0] frame;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_v [4];
  logic [3:0] valid_v;
  wire  [3:0] ready_v;
  wire  [3:0] utx_v;
  wire  [3:0] busy_v;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  sb_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: even parity, 1 stop.  1: odd parity.  2: no parity.  3: even, 2 stops.
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
  u_dut0 (.clk(clk), .rst_n(rst_n), .data(data_v[0]), .valid(valid_v[0]),
          .ready(ready_v[0]), .utx(utx_v[0]), .busy(busy_v[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
  u_dut1 (.clk(clk), .rst_n(rst_n), .data(data_v[1]), .valid(valid_v[1]),
          .ready(ready_v[1]), .utx(utx_v[1]), .busy(busy_v[1]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
  u_dut2 (.clk(clk), .rst_n(rst_n), .data(data_v[2]), .valid(valid_v[2]),
          .ready(ready_v[2]), .utx(utx_v[2]), .busy(busy_v[2]));

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
  u_dut3 (.clk(clk), .rst_n(rst_n), .data(data_v[3]), .valid(valid_v[3]),
          .ready(ready_v[3]), .utx(utx_v[3]), .busy(busy_v[3]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic int flen(input int idx);
    case (idx)
      2:       return 10;
      3:       return 12;
      default: return 11;
    endcase
  endfunction

  task automatic push(input int idx, input logic [11:0] f);
    sb_q.push_back('{idx: idx, frame: f});
  endtask

  // Presents a word with valid high and returns just after the transfer edge.
  task automatic xfer(input int idx, input logic [7:0] w, output int t);
    int n = 0;
    @(negedge clk);
    data_v[idx]  = w;
    valid_v[idx] = 1'b1;
    while (ready_v[idx] !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("xfer_ready[%0d]", idx), 32'(n < BUDGET), 1);
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic idle_gap(input int idx, input int gap);
    int n = 0;
    valid_v[idx] = 1'b0;
    while (ready_v[idx] !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input int idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb_q.size() != 0 || ready_v[idx] !== 1'b1) && n < BUDGET);
    check($sformatf("drain[%0d]", idx), 32'(n < BUDGET), 1);
  endtask

  // Samples the line every cycle of a frame, checks each bit is steady for a
  // full period and that the line is high in the cycle after the last stop.
  task automatic monitor(input int idx);
    logic [11:0] bits;
    int          glitch;
    bit          aborted;
    logic        s;
    sb_t         e;
    int          f;
    f = flen(idx);
    forever begin
      do @(negedge clk); while (utx_v[idx] !== 1'b0 || rst_n !== 1'b1);
      bits    = '0;
      glitch  = 0;
      aborted = 1'b0;
      for (int k = 0; k < f && !aborted; k++) begin
        for (int j = 0; j < CPB && !aborted; j++) begin
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            s = utx_v[idx];
            if (j == 0) bits[k] = s;
            else if (s !== bits[k]) glitch++;
            @(negedge clk);
          end
        end
      end
      if (aborted) begin
        while (rst_n !== 1'b1) @(negedge clk);
        continue;
      end
      check($sformatf("frame_present[%0d]", idx), 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check($sformatf("frame_inst[%0d]", idx), idx, e.idx);
        check($sformatf("frame_bits[%0d]", idx), bits, e.frame);
        check($sformatf("bit_steady[%0d]", idx), glitch, 0);
        check($sformatf("stop_idle[%0d]", idx), utx_v[idx], 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      automatic int k = i;
      fork
        monitor(k);
      join_none
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int         t, t1, t2, gap;
    logic [7:0] w;

    rst_n   = 1'b0;
    valid_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_utx",   utx_v,   4'hF);
    check("reset_ready", ready_v, 4'hF);
    check("reset_busy",  busy_v,  4'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1 with ready back at T+45.
    push(0, 11'b1_0_10100101_0);
    xfer(0, 8'hA5, t);
    valid_v[0] = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk);
      #1;
      if (k == 43) begin
        check("a5_ready_T44", ready_v[0], 0);
        check("a5_busy_T44",  busy_v[0],  1);
      end
      if (k == 44) begin
        check("a5_ready_T45", ready_v[0], 1);
        check("a5_busy_T45",  busy_v[0],  0);
      end
    end
    wait_drain(0);

    // 0x01 under odd, even and no parity.
    push(1, 11'b1_0_00000001_0);
    xfer(1, 8'h01, t);
    valid_v[1] = 1'b0;
    wait_drain(1);
    push(0, 11'b1_1_00000001_0);
    xfer(0, 8'h01, t);
    valid_v[0] = 1'b0;
    wait_drain(0);
    push(2, 10'b1_00000001_0);
    xfer(2, 8'h01, t);
    valid_v[2] = 1'b0;
    wait_drain(2);

    // valid held: 0x3C then 0xC3, data switched while the first frame runs.
    push(0, 11'b1_0_00111100_0);
    push(0, 11'b1_0_11000011_0);
    xfer(0, 8'h3C, t1);
    xfer(0, 8'hC3, t2);
    valid_v[0] = 1'b0;
    check("b2b_spacing", t2 - t1, 45);
    wait_drain(0);

    // Data churn and valid pulses during a frame must not disturb it.
    push(0, 11'b1_0_01011010_0);
    xfer(0, 8'h5A, t);
    valid_v[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      data_v[0]  = 8'($urandom);
      valid_v[0] = k[0];
      check("busy_ready_low", ready_v[0], 0);
    end
    valid_v[0] = 1'b0;
    wait_drain(0);
    repeat (3) @(negedge clk);
    check("no_extra_frame", busy_v[0], 0);

    // Asynchronous reset in the middle of data bit 3 (cycle T+18).
    xfer(0, 8'h00, t);
    valid_v[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_reset_utx", utx_v[0], 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_utx",   utx_v[0],   1);
    check("async_rst_ready", ready_v[0], 1);
    check("async_rst_busy",  busy_v[0],  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 11'b1_0_10010110_0);
    xfer(0, 8'h96, t);
    valid_v[0] = 1'b0;
    wait_drain(0);

    // Two stop bits, random words and random idle gaps.
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      push(3, {2'b11, ^w, w, 1'b0});
      xfer(3, w, t);
      gap = $urandom_range(0, 3);
      if (gap != 0) idle_gap(3, gap);
    end
    valid_v[3] = 1'b0;
    wait_drain(3);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. Serialises one parallel word per valid/ready transfer into an asynchronous frame on `utx`.
- Frame: start bit, data bits LSB-first, optional parity bit, stop bit(s).
- Sits beside the UART receiver in the host-link path, fed by the command/response logic.
- Frame format and bit timing match the receiver's, so a `utx`→`urx` loopback is lossless.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per bit period (50 MHz / 115200). Must be ≥ 2.
- DATA_BITS, 8: data bits per frame, range 5..9.
- PARITY_EN, 1: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- data  in  DATA_BITS  word to transmit; sampled only on transfer.
- valid  in  1  data is valid.
- ready  out  1  transmitter can accept a word; transfer occurs when valid && ready at a rising edge.
- utx  out  1  serial line, registered, idles high.
- busy  out  1  a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset: state=IDLE, utx=1, ready=1, busy=0, all counters cleared. Reset is asynchronous, so asserting it mid-frame forces utx=1 immediately and aborts the frame. No partial frame resumes after reset release.
- Frame length: F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
- FSM states:
  - IDLE: utx=1, ready=1. On valid → START. On the transfer edge:
    - shift register ← data.
    - parity bit ← ^data XOR PARITY_ODD.
    - baud counter ← CLKS_PER_BIT-1.
  - START: utx=0. On baud tc → DATA, bit counter ← DATA_BITS-1.
  - DATA: utx = shreg[0]. On baud tc: shift right one bit; if bit counter = 0 → (PARITY_EN ? PARITY : STOP), otherwise decrement the bit counter.
  - PARITY: utx = parity bit. On tc → STOP, stop counter ← STOP_BITS-1.
  - STOP: utx=1. On tc, if stop counter = 0 → IDLE, otherwise decrement it.
- Baud timer: down-counter reloaded to CLKS_PER_BIT-1 on every tc and on transfer. tc asserts when the count is 0 and state ≠ IDLE. Each bit therefore lasts exactly CLKS_PER_BIT cycles.
- utx is registered; its value is decoded from next_state and next shift contents.
- Timing with transfer at edge T:
  - utx=0 for cycles T+1 .. T+CLKS_PER_BIT.
  - Bit k occupies cycles T+1+k·CLKS_PER_BIT .. T+(k+1)·CLKS_PER_BIT.
  - FSM is back in IDLE at cycle T+1+F·CLKS_PER_BIT, with ready=1 in that cycle.
- Back-to-back frames: if valid is held, the next transfer occurs in that first IDLE cycle. This gives exactly one extra idle-high cycle between frames (the stop bit is lengthened by 1 clk), which is legal for the receiver.
- ready=0 whenever busy. valid and data changes while busy are ignored, and the captured word is immune to data changes.
- No output depends combinationally on valid.
- Width rules:
  - Bit counter: $clog2(DATA_BITS).
  - Baud counter: $clog2(CLKS_PER_BIT).
  - Stop counter: 1 bit.
  - No wrap-around: every counter is reloaded before it underflows.

Decomposition:
- uart_pkg (shared with the receiver): tx state enum {IDLE, START, DATA, PARITY, STOP}, default baud constant, parity-mode localparams.
- Sub-module uart_baud_tim: down-counter with reload, enable and tc output, parameterised by CLKS_PER_BIT. It is reusable by the receiver's bit timer.
- Top level holds the FSM, shift register, parity register and the utx register.

Test Plan:
- CLKS_PER_BIT=4, even parity, send 0xA5 → utx = 0,1,0,1,0,0,1,0,1,0,1, each level held 4 cycles, 44 cycles total. ready returns high at T+45.
- Odd parity: send 0x01 → parity bit 0. Even parity: send 0x01 → parity bit 1. PARITY_EN=0: send 0x01 → 10-bit frame, stop bit directly after data bit 7.
- valid held high with 0x3C then 0xC3 → two complete frames, one idle-high cycle between them. Second word is captured only after the first stop bit completes.
- During a frame, toggle data and pulse valid → line waveform unchanged, ready stays 0, no extra frame.
- Assert rst_n low during data bit 3 → utx=1, ready=1, busy=0 asynchronously. After release, a new transfer produces a clean full frame.
- Loopback to uart_rx, 256 random words, random valid gaps, STOP_BITS=2 → every word received intact, no parity errors.
